player_kinematics: RTL
======================

Name: player_kinematics

Overview:
Parametrised movement core for one player sprite, replacing the hard-coded motion logic of the current player controller. Runs entirely in the `clk` domain and advances only on a one-cycle `frame_tick` strobe. Adds an explicit motion state machine, grounded-only jumping, explosion knockback, death/respawn handling and per-ID spawn spacing. Sits between the collider, the keycode decoder and the sprite/bomb logic.

Parameters:
POS_W, 10, position width (pixels, unsigned)
VEL_W, 6, velocity width (signed, two's complement)
V_MAX, 7, velocity magnitude clamp per axis
GRAV_PERIOD, 6, ticks between gravity increments
MOVE_PERIOD, 6, ticks between horizontal input steps
JUMP_PERIOD, 32, minimum ticks between jumps
JUMP_IMPULSE, 4, upward speed applied on jump
X_MIN / X_MAX, 5 / 634, horizontal position limits (inclusive)
Y_MIN / Y_MAX, 5 / 474, vertical position limits (inclusive)
X_INIT / Y_INIT, 128 / 200, spawn position for id 0
X_SPACING, 128, spawn X offset per id step
ID_W, 1, player id width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle strobe per frame; all motion updates happen on it
id  in  ID_W  player index, static
mv_left / mv_right / mv_jump  in  1 each  decoded control levels
floor / ceil / wall_l / wall_r  in  1 each  collider contact flags
kick_valid  in  1  knockback request, sampled only on frame_tick
kick_vx / kick_vy  in  VEL_W each  signed knockback impulse
dead  in  1  level from health logic; forces DEAD
respawn  in  1  pulse; leaves DEAD
x_pos / y_pos  out  POS_W each  sprite centre
x_vel / y_vel  out  VEL_W each  signed velocity
state  out  2  motion state (player_pkg::mstate_t)
facing  out  1  0 = right, 1 = left
upd  out  1  one-cycle pulse, asserted the cycle after a processed frame_tick

Behaviour:
- Reset (reset==0 at a clk edge) sets: x_pos=X_INIT+id*X_SPACING, y_pos=Y_INIT, velocities 0, state=SPAWN, facing=0, upd=0, all period counters 0. Reset has priority over everything, including mid-tick.
- States:
  - SPAWN: holds the spawn position. Next tick goes to AIR.
  - GROUND
  - AIR
  - DEAD
- Any tick with dead=1 goes to DEAD. In DEAD: velocities are 0, position is frozen, inputs and kicks are ignored. respawn=1 while dead=0 loads the spawn position and goes to SPAWN. respawn while dead=1 is ignored.
- Period counters increment each tick. A counter "fires" when it equals PERIOD-1, then returns to 0. The jump counter saturates at JUMP_PERIOD-1 and clears only when a jump occurs.
- Per tick, in GROUND/AIR, evaluated in this order on working values:
  1. kick_valid: v += kick (signed add).
  2. Gravity fire and floor==0: vy += 1.
  3. Move fire:
     - exactly one of left/right held: vx -= 1 (left) or vx += 1 (right).
     - neither held and state GROUND: vx = 0.
     - both held: no change.
  4. Jump: mv_jump, state GROUND and jump counter saturated → vy = -JUMP_IMPULSE, counter cleared.
  5. Contacts:
     - floor and vy>0 → vy=0.
     - ceil and vy<0 → vy=1.
     - wall_l and vx<0 → vx=0.
     - wall_r and vx>0 → vx=0.
  6. Clamp each axis to [-V_MAX, +V_MAX].
  7. pos += v using signed POS_W+2 intermediate arithmetic. Clamp to [MIN, MAX]. A clamped axis gets its velocity zeroed.
- Next state after the update:
  - GROUND if floor=1 and vy>=0, and no jump or kick occurred this tick.
  - AIR otherwise.
- facing updates every tick from exclusive left/right; it holds when neither or both are held.
- Between ticks all registers hold. upd is asserted exactly one cycle after each tick that is processed with reset=1, including DEAD and SPAWN ticks.

Decomposition:
- Package player_pkg holds:
  - mstate_t {SPAWN, GROUND, AIR, DEAD}
  - the facing constants
  - a signed-saturate function used by the clamps
- Sub-module tick_divider (parameter PERIOD, SATURATE) is instantiated three times, for gravity, move and jump.

Test Plan:
1. Reset with id=1 (defaults), then one tick → x=256, y=200, state SPAWN→AIR, upd pulses one cycle later.
2. Free fall from rest with floor=0, 12 ticks → vy reaches 2; vy saturates at 7 and never exceeds it over 100 ticks.
3. GROUND, mv_jump held, 64 ticks → exactly 2 jumps, 32 ticks apart, each setting vy=-4. A jump held while in AIR has no effect.
4. mv_right held 42 ticks with floor=1 → vx steps to 7 and clamps; releasing it zeroes vx at the next move fire. facing=0; holding both keeps facing.
5. x=632, vx=+7 → x clamps to 634 and vx=0. kick_vx=-20 gives vx=-7 and state AIR.
6. dead=1 mid-air → state DEAD with position frozen. respawn while dead=0 → spawn position and SPAWN. Reset asserted mid-tick overrides both.

Source files
------------

// File: rtl/player_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | player_pkg: motion state, facing codes and signed saturation.   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package player_pkg;

  typedef enum logic [1:0] {
    SPAWN  = 2'd0,
    GROUND = 2'd1,
    AIR    = 2'd2,
    DEAD   = 2'd3
  } mstate_t;

  localparam logic FACE_RIGHT = 1'b0;
  localparam logic FACE_LEFT  = 1'b1;

  // Working width for velocity arithmetic, wide enough for kick + steps.
  localparam int SAT_W = 16;

  function automatic logic signed [SAT_W-1:0] sat_s(
    input logic signed [SAT_W-1:0] v,
    input int                      lim
  );
    logic signed [SAT_W-1:0] l;
    l = SAT_W'(lim);
    if (v > l)       return l;
    else if (v < -l) return -l;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tick_divider: frame-tick period counter, wrapping or saturating.|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tick_divider #(
  parameter int PERIOD   = 6,
  parameter bit SATURATE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic fire
);

  localparam int               CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign fire = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      if (SATURATE) begin
        // Holds at LAST until an explicit clear (a jump) consumes it.
        if (clear)      count <= '0;
        else if (!fire) count <= count + CNT_W'(1);
      end else begin
        count <= fire ? '0 : count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/player_kinematics.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | player_kinematics: per-frame motion core for one player sprite. |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module player_kinematics
  import player_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int VEL_W        = 6,
  parameter int V_MAX        = 7,
  parameter int GRAV_PERIOD  = 6,
  parameter int MOVE_PERIOD  = 6,
  parameter int JUMP_PERIOD  = 32,
  parameter int JUMP_IMPULSE = 4,
  parameter int X_MIN        = 5,
  parameter int X_MAX        = 634,
  parameter int Y_MIN        = 5,
  parameter int Y_MAX        = 474,
  parameter int X_INIT       = 128,
  parameter int Y_INIT       = 200,
  parameter int X_SPACING    = 128,
  parameter int ID_W         = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [ID_W-1:0]         id,
  input  logic                    mv_left,
  input  logic                    mv_right,
  input  logic                    mv_jump,
  input  logic                    floor,
  input  logic                    ceil,
  input  logic                    wall_l,
  input  logic                    wall_r,
  input  logic                    kick_valid,
  input  logic signed [VEL_W-1:0] kick_vx,
  input  logic signed [VEL_W-1:0] kick_vy,
  input  logic                    dead,
  input  logic                    respawn,
  output logic [POS_W-1:0]        x_pos,
  output logic [POS_W-1:0]        y_pos,
  output logic signed [VEL_W-1:0] x_vel,
  output logic signed [VEL_W-1:0] y_vel,
  output mstate_t                 state,
  output logic                    facing,
  output logic                    upd
);

  localparam int PW = POS_W + 2;
  localparam logic signed [PW-1:0]    XMIN_S = PW'(X_MIN);
  localparam logic signed [PW-1:0]    XMAX_S = PW'(X_MAX);
  localparam logic signed [PW-1:0]    YMIN_S = PW'(Y_MIN);
  localparam logic signed [PW-1:0]    YMAX_S = PW'(Y_MAX);
  localparam logic signed [SAT_W-1:0] ONE    = SAT_W'(1);
  localparam logic signed [SAT_W-1:0] ZERO   = '0;

  logic [POS_W-1:0]        spawn_x;
  logic                    grav_fire, move_fire, jump_ready, jump_now;
  logic [POS_W-1:0]        nx, ny;
  logic signed [VEL_W-1:0] nvx, nvy;
  mstate_t                 nstate;
  logic                    nface;
  logic signed [SAT_W-1:0] wvx, wvy;
  logic signed [PW-1:0]    px, py;

  assign spawn_x = POS_W'(X_INIT + int'(id) * X_SPACING);

  tick_divider #(.PERIOD(GRAV_PERIOD), .SATURATE(1'b0)) u_grav (
    .clk(clk), .reset(reset), .tick(frame_tick), .clear(1'b0), .fire(grav_fire)
  );
  tick_divider #(.PERIOD(MOVE_PERIOD), .SATURATE(1'b0)) u_move (
    .clk(clk), .reset(reset), .tick(frame_tick), .clear(1'b0), .fire(move_fire)
  );
  tick_divider #(.PERIOD(JUMP_PERIOD), .SATURATE(1'b1)) u_jump (
    .clk(clk), .reset(reset), .tick(frame_tick), .clear(jump_now), .fire(jump_ready)
  );

  always_comb begin
    nx       = x_pos;
    ny       = y_pos;
    nvx      = x_vel;
    nvy      = y_vel;
    nstate   = state;
    nface    = facing;
    jump_now = 1'b0;
    wvx      = SAT_W'(x_vel);
    wvy      = SAT_W'(y_vel);
    px       = '0;
    py       = '0;

    if (frame_tick) begin
      if (dead) begin
        nstate = DEAD;
        nvx    = '0;
        nvy    = '0;
      end else if (state == DEAD) begin
        if (respawn) begin
          nx     = spawn_x;
          ny     = POS_W'(Y_INIT);
          nstate = SPAWN;
        end
      end else begin
        if (mv_left && !mv_right)      nface = FACE_LEFT;
        else if (mv_right && !mv_left) nface = FACE_RIGHT;

        if (state == SPAWN) begin
          nstate = AIR;
        end else begin
          if (kick_valid) begin
            wvx = wvx + SAT_W'(kick_vx);
            wvy = wvy + SAT_W'(kick_vy);
          end
          if (grav_fire && !floor) wvy = wvy + ONE;
          if (move_fire) begin
            if (mv_left != mv_right)   wvx = mv_left ? wvx - ONE : wvx + ONE;
            else if (!mv_left && state == GROUND) wvx = ZERO;
          end
          if (mv_jump && state == GROUND && jump_ready) begin
            wvy      = -SAT_W'(JUMP_IMPULSE);
            jump_now = 1'b1;
          end

          if (floor && wvy > ZERO)  wvy = ZERO;
          if (ceil && wvy < ZERO)   wvy = ONE;
          if (wall_l && wvx < ZERO) wvx = ZERO;
          if (wall_r && wvx > ZERO) wvx = ZERO;

          wvx = sat_s(wvx, V_MAX);
          wvy = sat_s(wvy, V_MAX);

          // A screen-edge hit stops motion on that axis.
          px = $signed({2'b00, x_pos}) + PW'(wvx);
          py = $signed({2'b00, y_pos}) + PW'(wvy);
          if (px < XMIN_S)      begin nx = POS_W'(X_MIN); wvx = ZERO; end
          else if (px > XMAX_S) begin nx = POS_W'(X_MAX); wvx = ZERO; end
          else                        nx = px[POS_W-1:0];
          if (py < YMIN_S)      begin ny = POS_W'(Y_MIN); wvy = ZERO; end
          else if (py > YMAX_S) begin ny = POS_W'(Y_MAX); wvy = ZERO; end
          else                        ny = py[POS_W-1:0];

          nvx    = VEL_W'(wvx);
          nvy    = VEL_W'(wvy);
          nstate = (floor && wvy >= ZERO && !jump_now && !kick_valid) ? GROUND : AIR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_pos  <= spawn_x;
      y_pos  <= POS_W'(Y_INIT);
      x_vel  <= '0;
      y_vel  <= '0;
      state  <= SPAWN;
      facing <= FACE_RIGHT;
      upd    <= 1'b0;
    end else begin
      x_pos  <= nx;
      y_pos  <= ny;
      x_vel  <= nvx;
      y_vel  <= nvy;
      state  <= nstate;
      facing <= nface;
      upd    <= frame_tick;
    end
  end

endmodule
`default_nettype wire
